sw_debounce: RTL and testbench
==============================

Name: sw_debounce

Overview:
- Input-side conditioner for the board's slide switches, sitting between the raw `sw` pins and the combinational logic that drives `led`.
- Synchronises each raw switch bit into `clk` and filters out bounce with a per-bit stability counter.
- Presents clean levels to downstream logic, plus single-cycle rise/fall pulses for any logic that needs switch events rather than levels.

Parameters:
- WIDTH, 7: number of switch bits conditioned.
- DEBOUNCE_CYCLES, 1000000: consecutive clk cycles a synchronised input must differ from the stable value before it is accepted (10 ms at 100 MHz). Legal range ≥1.
- RESET_VAL, {WIDTH{1'b0}}: value loaded into sw_stable on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sw  input  WIDTH  raw, asynchronous switch inputs.
- sw_stable  output  WIDTH  debounced switch levels.
- sw_rise  output  WIDTH  one-cycle pulse per bit when sw_stable goes 0→1.
- sw_fall  output  WIDTH  one-cycle pulse per bit when sw_stable goes 1→0.
- sw_changed  output  1  OR-reduction of (sw_rise | sw_fall), registered-aligned with them.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sync stage 1 and stage 2 are loaded with RESET_VAL.
  - sw_stable=RESET_VAL.
  - All counters=0; sw_rise, sw_fall, sw_changed=0.
  - Outputs hold these values for as long as rst_n=0.
- Release of rst_n takes effect at the first rising clk edge after deassertion. No output changes in the release cycle.
- Synchroniser: two flops per bit (s1<=sw; s2<=s1). Only s2 feeds the filter.
- Per-bit filter, with cnt of width $clog2(DEBOUNCE_CYCLES+1):
  - If s2==sw_stable: cnt<=0.
  - If s2!=sw_stable and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - If s2!=sw_stable and cnt==DEBOUNCE_CYCLES-1: sw_stable<=s2, cnt<=0, and the matching rise/fall bit is set to 1 for exactly that next cycle.
- Per-bit state: IDLE (cnt==0, matching) / COUNTING (cnt>0). No other state.
- Latency: a raw change held steady updates sw_stable on the (DEBOUNCE_CYCLES+2)th rising edge after the change is first sampled by s1. Pulses are asserted in the same cycle sw_stable first shows the new value.
- Glitch rejection: any return of s2 to the sw_stable value before acceptance clears cnt. The full DEBOUNCE_CYCLES count restarts on the next mismatch.
- Pulses: sw_rise/sw_fall default 0 every cycle. sw_rise[i] and sw_fall[i] are never both 1. Multiple bits may pulse in the same cycle, with sw_changed=1 once.
- DEBOUNCE_CYCLES=1: acceptance occurs on the first mismatching cycle (pure synchroniser, latency 2 edges after the s1 sample).
- Counter saturation is impossible: cnt never exceeds DEBOUNCE_CYCLES-1.
- Bits are fully independent. A bounce on one bit never affects another bit's counter.
- Reset mid-count discards the partial count and any pending pulse.

Decomposition:
- Shared constants header: default DEBOUNCE_CYCLES for 100 MHz, plus a test-sized constant (4).
- Counter width is derived locally via $clog2.
- One natural sub-module, debounce_bit: 1-bit synchroniser + counter + stable flop + edge pulses.
- sw_debounce instantiates WIDTH copies in a generate loop and ORs the pulses into sw_changed.

Test Plan (WIDTH=7, DEBOUNCE_CYCLES=4, RESET_VAL=0):
- Reset: hold rst_n=0 with sw=7'h7F, then release → sw_stable=7'h00 and all pulses 0 during reset and the release cycle. sw_stable=7'h7F exactly 6 edges after the first post-reset sample, with sw_rise=7'h7F and sw_changed=1 for one cycle.
- Clean edge: sw[0] 0→1 held → sw_stable[0]=1 on the 6th edge after the s1 sample. sw_rise=7'h01 for one cycle, then 0; sw_fall stays 0.
- Bounce rejection: sw[3] toggles 1,0,1,0 with 2-cycle high periods, then returns low → sw_stable[3] stays 0 and no pulses occur. sw[3] then held high for 4+ synced cycles → accepted once.
- Simultaneous events: sw[2] rises and sw[5] falls (sw_stable[5] previously 1) on the same cycle → same acceptance edge gives sw_rise=7'h04, sw_fall=7'h20, sw_changed=1 for one cycle.
- Reset mid-count: sw[6] high for 2 synced cycles, then rst_n pulsed low → sw_stable=0 and no pulse. After release, sw[6] held → the full 4-cycle count restarts.
- DEBOUNCE_CYCLES=1 build: sw[1] single-cycle pulse of width ≥1 → sw_stable[1] follows s2 with one-cycle sw_rise then sw_fall pulses.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared constants and types for the slide-switch debouncer.
package sw_debounce_pkg;

    // Number of slide switches on the board.
    localparam int SW_WIDTH_DEFAULT = 7;

    // 10 ms of stability at a 100 MHz system clock.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    // Short filter length so simulations stay quick.
    localparam int DEBOUNCE_CYCLES_TEST = 4;

    // Per-bit filter state: IDLE means the synchronised input matches the
    // stable level; COUNTING means a mismatch is being timed.
    typedef enum logic {
        DB_IDLE     = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_e;

endpackage

// File: rtl/sw_debounce_if.sv
// Switch conditioner bus: raw switches in, debounced levels and edge events out.
interface sw_debounce_if
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH = SW_WIDTH_DEFAULT
) ();

    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    // Board/consumer side: drives raw switches, observes conditioned outputs.
    modport master (
        output sw,
        input  sw_stable,
        input  sw_rise,
        input  sw_fall,
        input  sw_changed
    );

    // Debouncer side.
    modport slave (
        input  sw,
        output sw_stable,
        output sw_rise,
        output sw_fall,
        output sw_changed
    );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, stable level
// register and single-cycle rise/fall pulses.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic sw_stable,
    output logic sw_rise,
    output logic sw_fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value on which a persisting mismatch is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_reg;
    logic             s2_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    db_state_e        state_reg;
    db_state_e        state_next;
    logic             stable_reg;
    logic             stable_next;
    logic             rise_reg;
    logic             rise_next;
    logic             fall_reg;
    logic             fall_next;

    // Two-flop synchroniser; only s2 is allowed to reach the filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= RESET_VAL;
            s2_reg <= RESET_VAL;
        end else begin
            s1_reg <= sw;
            s2_reg <= s1_reg;
        end
    end

    // Filter state register: counter, state, stable level and edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            state_reg  <= DB_IDLE;
            stable_reg <= RESET_VAL;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            state_reg  <= state_next;
            stable_reg <= stable_next;
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
        end
    end

    // Next-state logic: any match clears the count, and a mismatch that has
    // persisted for DEBOUNCE_CYCLES cycles is accepted with a one-cycle pulse.
    always_comb begin
        cnt_next    = cnt_reg;
        state_next  = state_reg;
        stable_next = stable_reg;
        rise_next   = 1'b0;
        fall_next   = 1'b0;

        if (s2_reg == stable_reg) begin
            cnt_next   = '0;
            state_next = DB_IDLE;
        end else if (cnt_reg == CNT_LAST) begin
            stable_next = s2_reg;
            cnt_next    = '0;
            state_next  = DB_IDLE;
            rise_next   = s2_reg;
            fall_next   = ~s2_reg;
        end else begin
            cnt_next   = cnt_reg + 1'b1;
            state_next = DB_COUNTING;
        end
    end

    assign sw_stable = stable_reg;
    assign sw_rise   = rise_reg;
    assign sw_fall   = fall_reg;

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: WIDTH independent debounce channels plus a
// combined "something changed" event flag.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int               WIDTH           = SW_WIDTH_DEFAULT,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b0}}
) (
    input  logic               clk,
    input  logic               rst_n,
    sw_debounce_if.slave       bus
);

    logic [WIDTH-1:0] stable_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    // One fully independent channel per switch bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            sw_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VAL       (RESET_VAL[gi])
            ) u_bit (
                .clk       (clk),
                .rst_n     (rst_n),
                .sw        (bus.sw[gi]),
                .sw_stable (stable_w[gi]),
                .sw_rise   (rise_w[gi]),
                .sw_fall   (fall_w[gi])
            );
        end
    endgenerate

    assign bus.sw_stable  = stable_w;
    assign bus.sw_rise    = rise_w;
    assign bus.sw_fall    = fall_w;
    // Built from the registered pulses, so it lines up with them exactly.
    assign bus.sw_changed = |(rise_w | fall_w);

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: a DEBOUNCE_CYCLES=4 build and a
// DEBOUNCE_CYCLES=1 build share the clock and reset.
module tb_sw_debounce;
    import sw_debounce_pkg::*;

    localparam int W = 7;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;
    logic [21:0] obs;
    logic [21:0] exp_v;

    sw_debounce_if #(.WIDTH(W)) bus_a ();
    sw_debounce_if #(.WIDTH(W)) bus_b ();

    sw_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_TEST),
        .RESET_VAL       (7'h00)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    sw_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (1),
        .RESET_VAL       (7'h00)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs {sw_stable, sw_rise, sw_fall, sw_changed} for one-shot comparison.
    function automatic logic [21:0] pack_a();
        return {bus_a.sw_stable, bus_a.sw_rise, bus_a.sw_fall, bus_a.sw_changed};
    endfunction

    function automatic logic [21:0] pack_b();
        return {bus_b.sw_stable, bus_b.sw_rise, bus_b.sw_fall, bus_b.sw_changed};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.sw = 7'h7F;
        bus_b.sw = 7'h00;
        tick(3);
        exp_v = {7'h00, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL reset_hold: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   reset_hold %h", obs); end
        exp_v = {7'h00, 7'h00, 7'h00, 1'b0}; obs = pack_b(); total_cnt++;
        if (obs !== exp_v) $display("FAIL reset_hold_b: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   reset_hold_b %h", obs); end
        rst_n = 1'b1;
        tick(1);
        exp_v = {7'h00, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL reset_release: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   reset_release %h", obs); end
        tick(4);
        exp_v = {7'h00, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL reset_edge5: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   reset_edge5 %h", obs); end
        tick(1);
        exp_v = {7'h7F, 7'h7F, 7'h00, 1'b1}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL reset_accept: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   reset_accept %h", obs); end
        tick(1);
        exp_v = {7'h7F, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL reset_pulse_end: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   reset_pulse_end %h", obs); end
        bus_a.sw = 7'h00;
        tick(8);
        exp_v = {7'h00, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL reset_settle_low: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   reset_settle_low %h", obs); end
    endtask

    task automatic test_clean_edge();
        bus_a.sw = 7'h01;
        tick(5);
        exp_v = {7'h00, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL clean_before: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   clean_before %h", obs); end
        tick(1);
        exp_v = {7'h01, 7'h01, 7'h00, 1'b1}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL clean_accept: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   clean_accept %h", obs); end
        tick(1);
        exp_v = {7'h01, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL clean_after: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   clean_after %h", obs); end
    endtask

    task automatic test_bounce();
        logic [6:0] pattern [12];
        pattern = '{7'h09, 7'h09, 7'h01, 7'h01, 7'h09, 7'h09,
                    7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01};
        for (int i = 0; i < 12; i++) begin
            bus_a.sw = pattern[i];
            tick(1);
            exp_v = {7'h01, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
            if (obs !== exp_v) $display("FAIL bounce_reject[%0d]: got %h expected %h", i, obs, exp_v);
            else begin pass_cnt++; $display("ok   bounce_reject[%0d] %h", i, obs); end
        end
        bus_a.sw = 7'h09;
        tick(5);
        exp_v = {7'h01, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL bounce_hold_before: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   bounce_hold_before %h", obs); end
        tick(1);
        exp_v = {7'h09, 7'h08, 7'h00, 1'b1}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL bounce_hold_accept: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   bounce_hold_accept %h", obs); end
        tick(1);
        exp_v = {7'h09, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL bounce_hold_after: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   bounce_hold_after %h", obs); end
    endtask

    task automatic test_simultaneous();
        bus_a.sw = 7'h29;
        tick(8);
        exp_v = {7'h29, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL simul_setup: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   simul_setup %h", obs); end
        bus_a.sw = 7'h0D;
        tick(5);
        exp_v = {7'h29, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL simul_before: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   simul_before %h", obs); end
        tick(1);
        exp_v = {7'h0D, 7'h04, 7'h20, 1'b1}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL simul_accept: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   simul_accept %h", obs); end
        tick(1);
        exp_v = {7'h0D, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL simul_after: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   simul_after %h", obs); end
    endtask

    task automatic test_reset_mid_count();
        bus_a.sw = 7'h00;
        tick(8);
        exp_v = {7'h00, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL midrst_setup: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   midrst_setup %h", obs); end
        bus_a.sw = 7'h40;
        tick(4);
        rst_n = 1'b0;
        #1;
        exp_v = {7'h00, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL midrst_assert: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   midrst_assert %h", obs); end
        tick(2);
        exp_v = {7'h00, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL midrst_hold: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   midrst_hold %h", obs); end
        rst_n = 1'b1;
        tick(5);
        exp_v = {7'h00, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL midrst_restart: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   midrst_restart %h", obs); end
        tick(1);
        exp_v = {7'h40, 7'h40, 7'h00, 1'b1}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL midrst_accept: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   midrst_accept %h", obs); end
        tick(1);
        exp_v = {7'h40, 7'h00, 7'h00, 1'b0}; obs = pack_a(); total_cnt++;
        if (obs !== exp_v) $display("FAIL midrst_after: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   midrst_after %h", obs); end
    endtask

    task automatic test_min_cycles();
        bus_b.sw = 7'h02;
        tick(1);
        bus_b.sw = 7'h00;
        exp_v = {7'h00, 7'h00, 7'h00, 1'b0}; obs = pack_b(); total_cnt++;
        if (obs !== exp_v) $display("FAIL min_edge1: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   min_edge1 %h", obs); end
        tick(1);
        exp_v = {7'h00, 7'h00, 7'h00, 1'b0}; obs = pack_b(); total_cnt++;
        if (obs !== exp_v) $display("FAIL min_edge2: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   min_edge2 %h", obs); end
        tick(1);
        exp_v = {7'h02, 7'h02, 7'h00, 1'b1}; obs = pack_b(); total_cnt++;
        if (obs !== exp_v) $display("FAIL min_rise: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   min_rise %h", obs); end
        tick(1);
        exp_v = {7'h00, 7'h00, 7'h02, 1'b1}; obs = pack_b(); total_cnt++;
        if (obs !== exp_v) $display("FAIL min_fall: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   min_fall %h", obs); end
        tick(1);
        exp_v = {7'h00, 7'h00, 7'h00, 1'b0}; obs = pack_b(); total_cnt++;
        if (obs !== exp_v) $display("FAIL min_quiet: got %h expected %h", obs, exp_v);
        else begin pass_cnt++; $display("ok   min_quiet %h", obs); end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        bus_a.sw  = 7'h00;
        bus_b.sw  = 7'h00;
        test_reset();
        test_clean_edge();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_min_cycles();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
